tape_port_sched: RTL and testbench

Scheduler for the SDRAM controller's tape port. It moves CDT bytes into SDRAM while a tape image downloads, then prefetches them back into a small FIFO for the tape player. One request is outstanding at a time. Writes from the download path always take priority over playback prefetch. The block sits between the ioctl download logic, the tape player and the `sdram` tape port.

---
 rtl/tape_port_sched.sv | 208 ++++++++++++++++++++
 tb/tb_tape_port_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_port_sched.sv
// Tape port scheduler: writes downloaded CDT bytes into SDRAM and prefetches them
// back into a small FIFO for the tape player, one toggle-acknowledged request at a time.
module tape_port_sched #(
    parameter int DEPTH_LOG2 = 2,
    parameter int ADDR_W     = 23
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_busy,
    output logic              dl_overrun,
    output logic [ADDR_W-1:0] tape_size,
    input  logic              play_en,
    input  logic              play_rewind,
    input  logic              play_pop,
    output logic [7:0]        play_data,
    output logic              play_valid,
    output logic              play_end,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_din,
    output logic              sd_wr,
    output logic              sd_rd,
    input  logic              sd_ack,
    input  logic [7:0]        sd_dout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {SYNC, IDLE, WR_WAIT, RD_WAIT} state_t;

    state_t                state;
    logic                  ack_prev;
    logic                  dl_active_q;
    logic                  discard;
    logic                  hold_valid;
    logic [ADDR_W-1:0]     hold_addr;
    logic [7:0]            hold_data;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [7:0]            fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2:0]   count;

    logic                  complete;
    logic                  dl_rise;
    logic                  flush;
    logic                  wr_go;
    logic                  rd_go;
    logic                  hold_take;
    logic                  dl_direct;
    logic                  hold_load;
    logic                  dl_drop;
    logic                  hold_valid_n;
    logic                  wr_busy_n;
    logic                  rd_busy_n;
    logic                  push;
    logic                  pop;
    logic [ADDR_W-1:0]     wr_end;
    logic [ADDR_W-1:0]     size_n;
    logic [ADDR_W-1:0]     rd_ptr_n;
    logic [DEPTH_LOG2:0]   count_n;
    logic [DEPTH_LOG2-1:0] rd_idx_n;
    logic [DEPTH_LOG2-1:0] wr_idx_n;
    logic [7:0]            head_n;

    // NOTE: every signal gets a value on every path through this block, so no latches form.
    always_comb begin
        complete  = (state != SYNC) && (sd_ack != ack_prev);
        dl_rise   = dl_active && !dl_active_q;
        flush     = dl_rise || play_rewind;

        wr_go     = (state == IDLE) && (hold_valid || dl_wr);
        rd_go     = (state == IDLE) && !wr_go && !flush && play_en && !dl_active
                    && (rd_ptr < tape_size) && (count < DEPTH_CNT);

        // The holding slot is vacated when its byte is issued, so it can refill at once.
        hold_take    = wr_go && hold_valid;
        dl_direct    = wr_go && !hold_valid;
        hold_load    = dl_wr && !dl_direct && (!hold_valid || hold_take);
        dl_drop      = dl_wr && hold_valid && !hold_take;
        hold_valid_n = hold_load || (hold_valid && !hold_take);

        wr_busy_n = wr_go || ((state == WR_WAIT) && !complete);
        rd_busy_n = rd_go || ((state == RD_WAIT) && !complete);

        push = complete && (state == RD_WAIT) && !discard && !flush;
        pop  = play_pop && (count != '0);

        wr_end = sd_addr + ADDR_W'(1);
        size_n = dl_rise ? '0 : tape_size;
        if (complete && (state == WR_WAIT) && (wr_end > size_n))
            size_n = wr_end;

        if (flush) begin
            rd_ptr_n = '0;
            count_n  = '0;
            rd_idx_n = '0;
            wr_idx_n = '0;
        end else begin
            rd_ptr_n = push ? rd_ptr + ADDR_W'(1) : rd_ptr;
            rd_idx_n = pop  ? rd_idx + DEPTH_LOG2'(1) : rd_idx;
            wr_idx_n = push ? wr_idx + DEPTH_LOG2'(1) : wr_idx;
            case ({push, pop})
                2'b10:   count_n = count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count_n = count - (DEPTH_LOG2 + 1)'(1);
                default: count_n = count;
            endcase
        end

        // A byte pushed into an otherwise empty FIFO becomes the new head directly.
        head_n = (push && (wr_idx == rd_idx_n)) ? sd_dout : fifo_mem[rd_idx_n];
    end

    // NOTE: the FIFO storage has no reset; count and play_valid keep stale entries unobservable.
    always_ff @(posedge clk_sys) begin
        if (push)
            fifo_mem[wr_idx] <= sd_dout;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= SYNC;
            ack_prev    <= 1'b0;
            dl_active_q <= 1'b0;
            discard     <= 1'b0;
            hold_valid  <= 1'b0;
            hold_addr   <= '0;
            hold_data   <= '0;
            rd_ptr      <= '0;
            rd_idx      <= '0;
            wr_idx      <= '0;
            count       <= '0;
            dl_busy     <= 1'b0;
            dl_overrun  <= 1'b0;
            tape_size   <= '0;
            play_data   <= '0;
            play_valid  <= 1'b0;
            play_end    <= 1'b1;
            sd_addr     <= '0;
            sd_din      <= '0;
            sd_wr       <= 1'b0;
            sd_rd       <= 1'b0;
        end else begin
            ack_prev    <= sd_ack;
            dl_active_q <= dl_active;

            hold_valid <= hold_valid_n;
            if (hold_load) begin
                hold_addr <= dl_addr;
                hold_data <= dl_data;
            end
            dl_busy <= hold_valid_n || wr_busy_n;

            if (dl_rise)
                dl_overrun <= 1'b0;
            if (dl_drop)
                dl_overrun <= 1'b1;

            tape_size  <= size_n;
            rd_ptr     <= rd_ptr_n;
            rd_idx     <= rd_idx_n;
            wr_idx     <= wr_idx_n;
            count      <= count_n;
            play_valid <= (count_n != '0);
            if (count_n != '0)
                play_data <= head_n;
            play_end   <= (rd_ptr_n == size_n) && (count_n == '0) && !rd_busy_n;

            case (state)
                SYNC: state <= IDLE;
                IDLE: begin
                    if (wr_go) begin
                        state   <= WR_WAIT;
                        sd_wr   <= 1'b1;
                        sd_addr <= hold_valid ? hold_addr : dl_addr;
                        sd_din  <= hold_valid ? hold_data : dl_data;
                    end else if (rd_go) begin
                        state   <= RD_WAIT;
                        sd_rd   <= 1'b1;
                        sd_addr <= rd_ptr;
                    end
                end
                WR_WAIT: begin
                    if (complete) begin
                        state <= IDLE;
                        sd_wr <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (complete) begin
                        state   <= IDLE;
                        sd_rd   <= 1'b0;
                        discard <= 1'b0;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_tape_port_sched.sv
// Directed bench for tape_port_sched: download, overrun, prefetch, rewind,
// download restart during a read, and reset mid-transaction.
module tb_tape_port_sched;

    localparam int ADDR_W = 23;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              dl_active;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              dl_busy;
    logic              dl_overrun;
    logic [ADDR_W-1:0] tape_size;
    logic              play_en;
    logic              play_rewind;
    logic              play_pop;
    logic [7:0]        play_data;
    logic              play_valid;
    logic              play_end;
    logic [ADDR_W-1:0] sd_addr;
    logic [7:0]        sd_din;
    logic              sd_wr;
    logic              sd_rd;
    logic              sd_ack;
    logic [7:0]        sd_dout;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0] tape_bytes [0:5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    always #5 clk_sys = ~clk_sys;

    tape_port_sched #(.DEPTH_LOG2(2), .ADDR_W(ADDR_W)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .dl_active   (dl_active),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_busy     (dl_busy),
        .dl_overrun  (dl_overrun),
        .tape_size   (tape_size),
        .play_en     (play_en),
        .play_rewind (play_rewind),
        .play_pop    (play_pop),
        .play_data   (play_data),
        .play_valid  (play_valid),
        .play_end    (play_end),
        .sd_addr     (sd_addr),
        .sd_din      (sd_din),
        .sd_wr       (sd_wr),
        .sd_rd       (sd_rd),
        .sd_ack      (sd_ack),
        .sd_dout     (sd_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Wait a bounded number of cycles for a read (want_rd=1) or write request.
    task automatic wait_req(input bit want_rd, input string tag);
        int n = 0;
        while (!(want_rd ? sd_rd : sd_wr) && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        check({tag, "_req"}, 32'(want_rd ? sd_rd : sd_wr), 1);
    endtask

    task automatic ack_after(input int n, input logic [7:0] d);
        tick(n);
        sd_dout = d;
        sd_ack  = ~sd_ack;
        tick(1);
    endtask

    task automatic write_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d,
                              input logic [31:0] exp_size);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick(1);
        dl_wr = 1'b0;
        check($sformatf("wr%0d_sd_wr", a), 32'(sd_wr), 1);
        check($sformatf("wr%0d_busy", a), 32'(dl_busy), 1);
        check($sformatf("wr%0d_addr", a), 32'(sd_addr), 32'(a));
        check($sformatf("wr%0d_din", a), 32'(sd_din), 32'(d));
        tick(3);
        check($sformatf("wr%0d_held", a), 32'(sd_wr), 1);
        ack_after(0, 8'h00);
        check($sformatf("wr%0d_drop", a), 32'(sd_wr), 0);
        check($sformatf("wr%0d_idle", a), 32'(dl_busy), 0);
        check($sformatf("wr%0d_size", a), 32'(tape_size), exp_size);
        tick(1);
    endtask

    task automatic read_byte(input logic [31:0] exp_addr, input logic [7:0] d);
        wait_req(1'b1, $sformatf("rd%0d", exp_addr));
        check($sformatf("rd%0d_addr", exp_addr), 32'(sd_addr), exp_addr);
        check($sformatf("rd%0d_nowr", exp_addr), 32'(sd_wr), 0);
        ack_after(2, d);
        check($sformatf("rd%0d_drop", exp_addr), 32'(sd_rd), 0);
    endtask

    initial begin
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        play_en = 1'b0; play_rewind = 1'b0; play_pop = 1'b0;
        sd_ack = 1'b1; sd_dout = '0;
        tick(2);
        check("rst_sd_wr", 32'(sd_wr), 0);
        check("rst_sd_rd", 32'(sd_rd), 0);
        check("rst_busy", 32'(dl_busy), 0);
        check("rst_overrun", 32'(dl_overrun), 0);
        check("rst_size", 32'(tape_size), 0);
        check("rst_valid", 32'(play_valid), 0);
        check("rst_data", 32'(play_data), 0);
        check("rst_end", 32'(play_end), 1);
        check("rst_addr", 32'(sd_addr), 0);
        check("rst_din", 32'(sd_din), 0);
        reset = 1'b0;
        tick(2);
        check("post_rst_noreq", 32'(sd_wr | sd_rd), 0);
        check("post_rst_end", 32'(play_end), 1);

        // Download three bytes; the stale ack across reset must not end the first write.
        dl_active = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++)
            write_byte(ADDR_W'(i), tape_bytes[i], 32'(i + 1));
        check("dl_size3", 32'(tape_size), 3);
        check("dl_no_overrun", 32'(dl_overrun), 0);

        // Two more strobes during an in-flight write: first held, second dropped.
        dl_wr = 1'b1; dl_addr = 3; dl_data = 8'h44;
        tick(1);
        check("ov_first_addr", 32'(sd_addr), 3);
        dl_addr = 4; dl_data = 8'h55;
        tick(1);
        dl_addr = 5; dl_data = 8'h66;
        tick(1);
        dl_wr = 1'b0;
        check("ov_flag", 32'(dl_overrun), 1);
        check("ov_busy", 32'(dl_busy), 1);
        ack_after(0, 8'h00);
        check("ov_wr_drop", 32'(sd_wr), 0);
        check("ov_still_busy", 32'(dl_busy), 1);
        check("ov_size4", 32'(tape_size), 4);
        tick(1);
        check("ov_held_issued", 32'(sd_wr), 1);
        check("ov_held_addr", 32'(sd_addr), 4);
        check("ov_held_din", 32'(sd_din), 'h55);
        ack_after(1, 8'h00);
        check("ov_size5", 32'(tape_size), 5);
        check("ov_idle", 32'(dl_busy), 0);
        tick(1);
        write_byte(ADDR_W'(5), 8'h66, 6);
        check("ov_sticky", 32'(dl_overrun), 1);
        dl_active = 1'b0;
        tick(1);

        // Prefetch with no pops: exactly four reads fill the FIFO.
        play_en = 1'b1;
        for (int i = 0; i < 4; i++)
            read_byte(32'(i), tape_bytes[i]);
        tick(6);
        check("pf_stop", 32'(sd_rd), 0);
        check("pf_valid", 32'(play_valid), 1);
        check("pf_head", 32'(play_data), 'h11);
        check("pf_not_end", 32'(play_end), 0);

        // Pop every byte; reads resume for addresses 4 and 5.
        for (int k = 0; k < 6; k++) begin
            check($sformatf("pop%0d_valid", k), 32'(play_valid), 1);
            check($sformatf("pop%0d_data", k), 32'(play_data), 32'(tape_bytes[k]));
            play_pop = 1'b1;
            tick(1);
            play_pop = 1'b0;
            if (k < 2)
                read_byte(32'(k + 4), tape_bytes[k + 4]);
        end
        check("pop_empty", 32'(play_valid), 0);
        check("pop_end", 32'(play_end), 1);
        play_pop = 1'b1;
        tick(1);
        play_pop = 1'b0;
        check("pop_underflow_valid", 32'(play_valid), 0);
        check("pop_underflow_end", 32'(play_end), 1);

        // Rewind, refetch 0 and 1, then rewind again while the read of 2 is in flight.
        play_rewind = 1'b1;
        tick(1);
        play_rewind = 1'b0;
        check("rw_not_end", 32'(play_end), 0);
        read_byte(0, tape_bytes[0]);
        read_byte(1, tape_bytes[1]);
        wait_req(1'b1, "rw_rd2");
        check("rw_rd2_addr", 32'(sd_addr), 2);
        play_rewind = 1'b1;
        tick(1);
        play_rewind = 1'b0;
        check("rw_flushed", 32'(play_valid), 0);
        ack_after(0, tape_bytes[2]);
        check("rw_rd_drop", 32'(sd_rd), 0);
        check("rw_discarded", 32'(play_valid), 0);
        read_byte(0, tape_bytes[0]);
        check("rw_refill_valid", 32'(play_valid), 1);
        check("rw_refill_head", 32'(play_data), 'h11);

        // Download restarts while the read of address 1 is in flight.
        wait_req(1'b1, "dr_rd1");
        check("dr_rd1_addr", 32'(sd_addr), 1);
        dl_active = 1'b1;
        dl_wr = 1'b1; dl_addr = 0; dl_data = 8'hA5;
        tick(1);
        dl_wr = 1'b0;
        check("dr_busy", 32'(dl_busy), 1);
        check("dr_wr_waits", 32'(sd_wr), 0);
        check("dr_size0", 32'(tape_size), 0);
        check("dr_flushed", 32'(play_valid), 0);
        check("dr_overrun_clr", 32'(dl_overrun), 0);
        ack_after(1, tape_bytes[1]);
        check("dr_rd_drop", 32'(sd_rd), 0);
        check("dr_discarded", 32'(play_valid), 0);
        wait_req(1'b0, "dr_wr");
        check("dr_wr_addr", 32'(sd_addr), 0);
        check("dr_wr_din", 32'(sd_din), 'hA5);
        ack_after(2, 8'h00);
        check("dr_size1", 32'(tape_size), 1);
        check("dr_idle", 32'(dl_busy), 0);
        tick(5);
        check("dr_no_fetch", 32'(sd_rd), 0);

        // Reset in the middle of a write, with a late ack toggle during reset.
        dl_wr = 1'b1; dl_addr = 1; dl_data = 8'hB6;
        tick(1);
        dl_wr = 1'b0;
        check("mr_sd_wr", 32'(sd_wr), 1);
        #3 reset = 1'b1;
        #1;
        check("mr_async_wr", 32'(sd_wr), 0);
        check("mr_async_busy", 32'(dl_busy), 0);
        sd_ack = ~sd_ack;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("mr_noreq", 32'(sd_wr | sd_rd), 0);
        check("mr_size0", 32'(tape_size), 0);
        write_byte(ADDR_W'(0), 8'h5A, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
